// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises request lines, latches rising edges, masks them and resolves a lowest-index vector on acknowledge.
module interrupt_controller #(
    parameter int         N_SRC       = 8,
    parameter logic [7:0] PORT_STATUS = 8'hF0,
    parameter logic [7:0] PORT_MASK   = 8'hF1,
    parameter logic [7:0] PORT_CLEAR  = 8'hF2,
    parameter logic [7:0] PORT_VECTOR = 8'hF3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [N_SRC-1:0] IRQ_IN,
    input  logic [7:0]       PORT_ID,
    input  logic [7:0]       OUT_PORT,
    input  logic             IO_STRB,
    input  logic             INT_ACK,
    output logic             INTERRUPT,
    output logic [7:0]       IN_DATA,
    output logic             IN_HIT
);
    logic [N_SRC-1:0] s1_q, s2_q, prev_q, pend_q, pend_d, mask_q, mask_d;
    logic [N_SRC-1:0] rise, act, clr, ack_clr;
    logic [1:0]       warm_q;
    logic [7:0]       vector_q, vector_d;
    logic [2:0]       sel;
    logic             any, wr_mask, wr_clear;

    // warm_q covers the two cycles after reset in which s2 and prev fill together, so a held line is not an edge
    assign rise     = s2_q & ~prev_q & {N_SRC{~|warm_q}};
    assign act      = pend_q & mask_q;
    assign wr_mask  = IO_STRB && PORT_ID == PORT_MASK;
    assign wr_clear = IO_STRB && PORT_ID == PORT_CLEAR;
    assign clr      = wr_clear ? OUT_PORT[N_SRC-1:0] : '0;
    assign ack_clr  = INT_ACK && any ? N_SRC'(1) << sel : '0;

    // lowest enabled pending source wins the acknowledge
    always_comb begin
        sel = 3'd0;
        any = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (act[i]) begin
                sel = 3'(i);
                any = 1'b1;
            end
        end
    end

    // next state: a new edge beats clear and acknowledge on the same bit
    always_comb begin
        pend_d   = rise | (pend_q & ~clr & ~ack_clr);
        mask_d   = wr_mask ? OUT_PORT[N_SRC-1:0] : mask_q;
        vector_d = INT_ACK ? (any ? {1'b1, 4'b0, sel} : 8'h00) : vector_q;
    end

    // synchroniser, edge history and programmable registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q     <= '0;
            s2_q     <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            mask_q   <= '0;
            vector_q <= 8'h00;
            warm_q   <= 2'b11;
        end else begin
            s1_q     <= IRQ_IN;
            s2_q     <= s1_q;
            prev_q   <= |warm_q ? s1_q : s2_q;
            pend_q   <= pend_d;
            mask_q   <= mask_d;
            vector_q <= vector_d;
            warm_q   <= warm_q >> 1;
        end
    end

    // read mux and interrupt line, both purely from registers and PORT_ID
    always_comb begin
        INTERRUPT = |act;
        IN_HIT    = PORT_ID == PORT_STATUS || PORT_ID == PORT_MASK ||
                    PORT_ID == PORT_CLEAR  || PORT_ID == PORT_VECTOR;
        IN_DATA   = PORT_ID == PORT_STATUS ? 8'(pend_q) :
                    PORT_ID == PORT_MASK   ? 8'(mask_q) :
                    PORT_ID == PORT_VECTOR ? vector_q : 8'h00;
    end
endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller: directed and randomized checks against a sample-history reference model.
module tb_interrupt_controller;
    logic       CLK = 1'b0, RESET = 1'b1, IO_STRB = 1'b0, INT_ACK = 1'b0;
    logic [7:0] IRQ_IN = 8'h00, PORT_ID = 8'h00, OUT_PORT = 8'h00;
    logic       INTERRUPT, IN_HIT;
    logic [7:0] IN_DATA;
    int         tot = 0, bad = 0;
    logic [7:0] m_pend = 8'h00, m_mask = 8'h00, m_vec = 8'h00;
    logic [7:0] hist[$];

    always #5 CLK = ~CLK;

    interrupt_controller dut (
        .CLK(CLK), .RESET(RESET), .IRQ_IN(IRQ_IN), .PORT_ID(PORT_ID),
        .OUT_PORT(OUT_PORT), .IO_STRB(IO_STRB), .INT_ACK(INT_ACK),
        .INTERRUPT(INTERRUPT), .IN_DATA(IN_DATA), .IN_HIT(IN_HIT)
    );

    task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tot++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] p, input logic [7:0] exp, input logic hit);
        PORT_ID = p;
        #1;
        cmp(tag, IN_DATA, exp);
        cmp({tag, "_hit"}, 8'(IN_HIT), 8'(hit));
    endtask

    // one clock: drive the bus, let the model follow the edge, then drop the strobes
    task automatic cyc(input logic w = 1'b0, input logic [7:0] p = 8'h00,
                       input logic [7:0] d = 8'h00, input logic a = 1'b0);
        logic [7:0] act, rise, clr, ackc;
        IO_STRB = w; PORT_ID = p; OUT_PORT = d; INT_ACK = a;
        @(posedge CLK);
        if (RESET) begin
            m_pend = 8'h00; m_mask = 8'h00; m_vec = 8'h00;
            hist = '{IRQ_IN, IRQ_IN, IRQ_IN};
        end else begin
            rise = hist[1] & ~hist[2];
            act  = m_pend & m_mask;
            clr  = (w && p == 8'hF2) ? d : 8'h00;
            ackc = 8'h00;
            if (a) begin
                m_vec = 8'h00;
                for (int i = 7; i >= 0; i--)
                    if (act[i]) begin
                        m_vec = 8'h80 | 8'(i);
                        ackc  = 8'h01 << i;
                    end
            end
            m_pend = rise | (m_pend & ~clr & ~ackc);
            if (w && p == 8'hF1) m_mask = d;
            hist.push_front(IRQ_IN);
            void'(hist.pop_back());
        end
        #1;
        IO_STRB = 1'b0; INT_ACK = 1'b0;
    endtask

    task automatic check_all(input string tag);
        logic [7:0] p;
        cmp({tag, "_int"}, 8'(INTERRUPT), 8'(|(m_pend & m_mask)));
        rd({tag, "_status"}, 8'hF0, m_pend, 1'b1);
        rd({tag, "_mask"}, 8'hF1, m_mask, 1'b1);
        rd({tag, "_clear"}, 8'hF2, 8'h00, 1'b1);
        rd({tag, "_vector"}, 8'hF3, m_vec, 1'b1);
        p = 8'($urandom_range(0, 255));
        if (p >= 8'hF0 && p <= 8'hF3) p = p - 8'h10;
        rd({tag, "_other"}, p, 8'h00, 1'b0);
    endtask

    initial begin
        int hold;
        int r;
        cyc(); cyc();
        RESET = 1'b0;
        check_all("reset");
        cmp("reset_int_const", 8'(INTERRUPT), 8'h00);
        cyc(1'b1, 8'hF1, 8'hFF);
        IRQ_IN[3] = 1'b1;
        cyc(); cyc();
        rd("irq3_edge2", 8'hF0, 8'h00, 1'b1);
        cyc();
        rd("irq3_edge3", 8'hF0, 8'h08, 1'b1);
        cmp("irq3_int", 8'(INTERRUPT), 8'h01);
        check_all("irq3");
        IRQ_IN[3] = 1'b0;
        cyc(); cyc(); cyc();
        cyc(1'b1, 8'hF2, 8'h08);
        check_all("irq3_clr");
        IRQ_IN[5] = 1'b1; IRQ_IN[2] = 1'b1;
        cyc(); cyc(); cyc();
        IRQ_IN = 8'h00;
        cyc(.a(1'b1));
        rd("ack1_vec", 8'hF3, 8'h82, 1'b1);
        rd("ack1_pend", 8'hF0, 8'h20, 1'b1);
        cmp("ack1_int", 8'(INTERRUPT), 8'h01);
        cyc(.a(1'b1));
        rd("ack2_vec", 8'hF3, 8'h85, 1'b1);
        rd("ack2_pend", 8'hF0, 8'h00, 1'b1);
        cmp("ack2_int", 8'(INTERRUPT), 8'h00);
        check_all("ack2");
        cyc(1'b1, 8'hF1, 8'h00);
        IRQ_IN[0] = 1'b1;
        cyc(); cyc();
        IRQ_IN[0] = 1'b0;
        cyc(); cyc();
        rd("masked_pend", 8'hF0, 8'h01, 1'b1);
        cmp("masked_int", 8'(INTERRUPT), 8'h00);
        cyc(1'b1, 8'hF1, 8'h01);
        cmp("unmask_int", 8'(INTERRUPT), 8'h01);
        cyc(1'b1, 8'hF2, 8'h01);
        cmp("clear_int", 8'(INTERRUPT), 8'h00);
        check_all("clear0");
        IRQ_IN[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 9) cyc(1'b1, 8'hF2, 8'h02);
            else cyc();
            check_all("hold1");
        end
        rd("hold1_end", 8'hF0, 8'h00, 1'b1);
        IRQ_IN[1] = 1'b0;
        IRQ_IN[4] = 1'b1;
        cyc(); cyc(); cyc();
        IRQ_IN[4] = 1'b0;
        cyc(); cyc();
        IRQ_IN[4] = 1'b1;
        cyc(); cyc();
        cyc(1'b1, 8'hF2, 8'h10);
        rd("edge_vs_clear", 8'hF0, 8'h10, 1'b1);
        check_all("edge_vs_clear");
        IRQ_IN[4] = 1'b0;
        cyc(1'b1, 8'hF2, 8'hFF);
        cyc(.a(1'b1));
        rd("ack_none", 8'hF3, 8'h00, 1'b1);
        cyc(1'b1, 8'hF1, 8'hFF);
        IRQ_IN = 8'hFF;
        cyc(); cyc(); cyc();
        rd("all_pend", 8'hF0, 8'hFF, 1'b1);
        RESET = 1'b1;
        cyc();
        RESET = 1'b0;
        rd("rst_pend", 8'hF0, 8'h00, 1'b1);
        rd("rst_mask", 8'hF1, 8'h00, 1'b1);
        cmp("rst_int", 8'(INTERRUPT), 8'h00);
        for (int k = 0; k < 5; k++) cyc();
        rd("rst_held_no_edge", 8'hF0, 8'h00, 1'b1);
        check_all("rst_held");
        IRQ_IN = 8'h00;
        cyc(); cyc(); cyc();
        hold = 0;
        for (int k = 0; k < 400; k++) begin
            if (hold == 0) begin
                IRQ_IN = 8'($urandom);
                hold = $urandom_range(2, 5);
            end
            hold--;
            r = $urandom_range(0, 9);
            case (r)
                0, 1: cyc(1'b1, 8'hF1, 8'($urandom));
                2, 3: cyc(1'b1, 8'hF2, 8'($urandom));
                4, 5: cyc(.a(1'b1));
                6: cyc(1'b1, ($urandom_range(0, 1) != 0) ? 8'hF0 : 8'hF3, 8'($urandom));
                7: cyc(1'b1, 8'hF2, 8'($urandom), 1'b1);
                default: cyc();
            endcase
            check_all("rand");
        end
        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end
endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Interrupt source aggregator that drives the MCU control unit's INTERRUPT input and is programmed over the CPU port bus.
- Synchronises up to 8 asynchronous request lines and latches rising edges as pending bits.
- Masks the pending bits and resolves a lowest-index-wins vector when the CPU acknowledges.
- Exposes status, mask, clear and vector registers through IN/OUT port IDs.
- Sits between board-level event sources and the control unit, on the same PORT_ID/IO_STRB bus as the other I/O peripherals.

## Interface
- N_SRC, 8: number of request lines, legal range 1..8.
- PORT_STATUS, 8'hF0: read-only pending register.
- PORT_MASK, 8'hF1: read/write enable mask.
- PORT_CLEAR, 8'hF2: write-1-to-clear pending; reads return 0.
- PORT_VECTOR, 8'hF3: read-only acknowledged-vector register.
- CLK  in  1  system clock; all state updates on the rising edge.
- RESET  in  1  synchronous, active-high.
- IRQ_IN  in  N_SRC  asynchronous request lines, active-high.
- PORT_ID  in  8  port address from the CPU.
- OUT_PORT  in  8  write data from the CPU.
- IO_STRB  in  1  one-cycle write strobe from the OUT instruction.
- INT_ACK  in  1  one-cycle pulse while the control unit is in its interrupt-entry state.
- INTERRUPT  out  1  interrupt request to the control unit.
- IN_DATA  out  8  read data for the current PORT_ID, combinational.
- IN_HIT  out  1  high when PORT_ID matches any of the four ports; the top-level IN mux uses it.

## Operation
- Synchroniser:
  - Each IRQ_IN bit passes through a 2-FF synchroniser (s1, s2).
  - A previous-value register (prev) follows s2.
  - Edge condition: edge[i] = s2[i] & ~prev[i].
- Pending (PEND, N_SRC bits). Per-bit priority, highest first:
  - edge[i] sets the bit.
  - Otherwise a CLEAR write with OUT_PORT[i]=1 clears it.
  - Otherwise an INT_ACK that selects source i clears it.
  - Otherwise the bit holds.
- Mask (MASK, N_SRC bits):
  - Loaded from OUT_PORT[N_SRC-1:0] when IO_STRB=1 and PORT_ID=PORT_MASK.
  - Writes to STATUS and VECTOR are ignored.
- INTERRUPT = |(PEND & MASK). It is driven only from registers, so it is glitch-free.
- Acknowledge:
  - On INT_ACK, sel = lowest index i with PEND[i]&MASK[i].
  - If such an i exists: VECTOR <= {1'b1, 4'b0, sel[2:0]} and PEND[sel] clears.
  - If none exists: VECTOR <= 8'h00 and PEND is unchanged.
  - Only one source is acknowledged per INT_ACK.
- Reads:
  - STATUS returns PEND zero-extended to 8 bits.
  - MASK returns MASK zero-extended to 8 bits.
  - CLEAR returns 8'h00.
  - VECTOR returns the VECTOR register.
  - Any other PORT_ID returns IN_DATA=8'h00 and IN_HIT=0.
  - Reads have no side effects.
- Unused upper bits (N_SRC<8) read as 0 and ignore writes.

## Timing
- Reset values:
  - s1, s2, prev, PEND, MASK and VECTOR are 0.
  - INTERRUPT=0; IN_DATA follows PORT_ID (reads 0 for all ports).
- RESET asserted mid-operation discards all pending requests on the next edge. A line still high after reset is not treated as an edge, because s2 and prev both fill with 1 together.
- Request latency: an IRQ_IN rise that meets setup before edge E0 gives s1=1 after E0, s2=1 after E1, and PEND=1 after E2. INTERRUPT follows in the same cycle as PEND if the bit is masked in.
- A pulse shorter than one CLK period may be missed. Sources must hold for at least 2 cycles.
- MASK, CLEAR and ACK take effect on the edge at the end of the strobe or ACK cycle, and INTERRUPT reflects the change immediately after that edge.
- Conflict resolution:
  - A new edge on bit i in the same cycle as a CLEAR or ACK of bit i leaves PEND[i]=1.
  - CLEAR and ACK in the same cycle: both apply. ACK selects from the pre-clear PEND&MASK.
- A level held high produces exactly one pending event until it falls and rises again.
- IN_DATA and IN_HIT are pure combinational functions of PORT_ID and the registers, valid in the same cycle, so the CPU's IN instruction completes in its EXEC cycle.

## Test plan
- Reset, then a MASK write of 8'hFF, then IRQ_IN[3] rise:
  - PEND=8'h08 and INTERRUPT=1 exactly 3 edges after the rise.
  - A STATUS read returns 8'h08.
- IRQ_IN[5] and IRQ_IN[2] rise together, MASK=8'hFF, then INT_ACK:
  - VECTOR=8'h82, PEND=8'h20, INTERRUPT stays 1.
  - A second INT_ACK gives VECTOR=8'h85, PEND=0, INTERRUPT=0.
- MASK=8'h00 and IRQ_IN[0] pulses:
  - PEND=8'h01, INTERRUPT=0.
  - A MASK write of 8'h01 raises INTERRUPT on the next edge.
  - A CLEAR write of 8'h01 drops it.
- IRQ_IN[1] held high for 20 cycles:
  - A single pending event.
  - A CLEAR mid-hold leaves PEND=0 for the rest of the hold.
- Edge on bit 4 in the same cycle as a CLEAR write of 8'h10: PEND[4]=1 afterwards.
- INT_ACK with nothing pending gives VECTOR=8'h00. RESET pulsed while PEND=8'hFF gives PEND=0, MASK=0, INTERRUPT=0.
